// File: rtl/bit_add.sv
// Registered ripple-carry adder: WIDTH full-adder stages feeding a single
// output register for sum, carry-out and signed overflow.
module bit_add #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    // k[i] is the carry into stage i; k[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    assign k[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic p;
        assign p          = a[i] ^ b[i];
        assign sum_d[i]   = p ^ k[i];
        assign k[i+1]     = (a[i] & b[i]) | (k[i] & p);
    end

    // Signed overflow: carries into and out of the sign bit disagree.
    assign ovf_d = k[WIDTH] ^ k[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= '0;
            c   <= 1'b0;
            ovf <= 1'b0;
        end else begin
            s   <= sum_d;
            c   <= k[WIDTH];
            ovf <= ovf_d;
        end
    end

endmodule

// File: tb/tb_bit_add.sv
// Self-checking bench for bit_add: directed, back-to-back, exhaustive and
// random vectors against an integer-arithmetic reference model.
module tb_bit_add;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       c;
    logic       ovf;

    int checks;
    int errors;

    // Expected {ovf, c, s} for results still in flight.
    logic [5:0] exp_q[$];

    bit_add #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .c     (c),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned sum for {c,s}, signed range test for ovf.
    function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        int usum;
        int ssum;
        logic [4:0] u5;
        logic o;
        usum = int'(ma) + int'(mb) + int'(mc);
        ssum = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        o    = (ssum > 7) || (ssum < -8);
        u5   = usum[4:0];
        return {o, u5};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a = 4'hF; b = 4'hF; cin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({ovf, c, s} !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold: got ovf=%b c=%b s=%h, want 0 0 0", ovf, c, s);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ovf, c, s} !== model(4'hF, 4'hF, 1'b1)) begin
            errors++;
            $display("FAIL reset_release: got ovf=%b c=%b s=%h, want %b", ovf, c, s, model(4'hF, 4'hF, 1'b1));
        end
        // Asynchronous assertion between edges must clear immediately.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ovf, c, s} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: got ovf=%b c=%b s=%h, want 0 0 0", ovf, c, s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'h0; b = 4'h0; cin = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [3:0] va[4] = '{4'b0001, 4'b0101, 4'b1001, 4'b0101};
        logic [3:0] vb[4] = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};
        logic       vc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0] want[4] = '{6'b0_0_0100, 6'b1_0_1011, 6'b1_1_0100, 6'b0_1_0011};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i];
            @(negedge clk);
            checks++;
            if ({ovf, c, s} !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d: got ovf=%b c=%b s=%b, want %b", i, ovf, c, s, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va[4] = '{4'b0001, 4'b0101, 4'b1001, 4'b0101};
        logic [3:0] vb[4] = '{4'b0010, 4'b0110, 4'b1010, 4'b1110};
        logic       vc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0] e;
        exp_q.delete();
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({ovf, c, s} !== e) begin
                    errors++;
                    $display("FAIL b2b_%0d: got ovf=%b c=%b s=%b, want %b", i - 1, ovf, c, s, e);
                end
            end
            if (i < 4) begin
                a = va[i]; b = vb[i]; cin = vc[i];
                exp_q.push_back(model(va[i], vb[i], vc[i]));
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] n;
        logic [5:0] e;
        exp_q.delete();
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({ovf, c, s} !== e) begin
                    errors++;
                    $display("FAIL sweep_%0d: got ovf=%b c=%b s=%b, want %b", i - 1, ovf, c, s, e);
                end
            end
            if (i < 512) begin
                n = 9'(i);
                a = n[3:0]; b = n[7:4]; cin = n[8];
                exp_q.push_back(model(n[3:0], n[7:4], n[8]));
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] e;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        exp_q.delete();
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({ovf, c, s} !== e) begin
                    errors++;
                    $display("FAIL random_%0d: got ovf=%b c=%b s=%b, want %b", i - 1, ovf, c, s, e);
                end
            end
            if (i < 200) begin
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                rc = 1'($urandom_range(0, 1));
                a = ra; b = rb; cin = rc;
                exp_q.push_back(model(ra, rb, rc));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_exhaustive();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
